// File: rtl/jtdd_romarb_if.sv
// Bus bundle between the three CPU ROM ports, the ROM arbiter and the SDRAM read channel.
// slave: the arbiter side; master: requesters plus SDRAM controller.
interface jtdd_romarb_if #(
  parameter int AW = 18,
  parameter int DW = 8
);
  logic [2:0]         req_cs;
  logic [2:0][AW-1:0] req_addr;   // {snd,sub,main}
  logic [2:0][DW-1:0] req_data;
  logic [2:0]         req_ok;
  logic               flush;
  logic               sdr_req;
  logic [AW-1:0]      sdr_addr;
  logic               sdr_ack;
  logic               sdr_dst;
  logic [DW-1:0]      sdr_din;

  modport slave (
    input  req_cs, req_addr, flush, sdr_ack, sdr_dst, sdr_din,
    output req_data, req_ok, sdr_req, sdr_addr
  );

  modport master (
    output req_cs, req_addr, flush, sdr_ack, sdr_dst, sdr_din,
    input  req_data, req_ok, sdr_req, sdr_addr
  );
endinterface

// File: rtl/jtdd_romarb.sv
// ROM read arbiter for the DD core: one-entry cache per CPU, misses served round-robin.
// Optional SDRAM timeout recovery is enabled with `define JTDD_ROMARB_TIMEOUT_EN.

module jtdd_romarb_lane #(
  parameter int AW = 18,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          flush,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] data,
  output logic          ok,
  output logic          miss
);
  logic          vld;
  logic [AW-1:0] caddr;
  logic          hit;

  assign hit  = vld && (caddr == addr);
  assign ok   = cs && hit;
  assign miss = cs && !hit;

  // flush has priority so a fill landing on the flush cycle is dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld   <= 1'b0;
      caddr <= '0;
      data  <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (wr) begin
      vld   <= 1'b1;
      caddr <= wr_addr;
      data  <= wr_data;
    end
  end
endmodule

module jtdd_romarb #(
  parameter int AW   = 18,
  parameter int DW   = 8,
  parameter int TOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  jtdd_romarb_if.slave       bus,
  output logic               busy,
  output logic               timeout_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} st_t;

  st_t        st;
  logic [1:0] gnt, rr, pick, c1, c2;
  logic [2:0] miss, wr;
  logic       fill;

  // first missing requester at or after rr, wrapping 2 -> 0
  always_comb begin
    c1   = (rr == 2'd2) ? 2'd0 : rr + 2'd1;
    c2   = (rr == 2'd0) ? 2'd2 : rr - 2'd1;
    pick = miss[rr] ? rr : (miss[c1] ? c1 : c2);
  end

  // ack and data strobe in the same REQ cycle complete the read directly
  assign fill = ((st == WAIT) && bus.sdr_dst) ||
                ((st == REQ) && bus.sdr_ack && bus.sdr_dst);

  for (genvar i = 0; i < 3; i++) begin : g_lane
    assign wr[i] = fill && (gnt == 2'(i));
    jtdd_romarb_lane #(.AW(AW), .DW(DW)) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .cs      (bus.req_cs[i]),
      .addr    (bus.req_addr[i]),
      .flush   (bus.flush),
      .wr      (wr[i]),
      .wr_addr (bus.sdr_addr),
      .wr_data (bus.sdr_din),
      .data    (bus.req_data[i]),
      .ok      (bus.req_ok[i]),
      .miss    (miss[i])
    );
  end

`ifdef JTDD_ROMARB_TIMEOUT_EN
  localparam logic [7:0] TLIM = 8'(TOUT - 1);
  logic [7:0] cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st           <= IDLE;
      gnt          <= 2'd0;
      rr           <= 2'd0;
      busy         <= 1'b0;
      bus.sdr_req  <= 1'b0;
      bus.sdr_addr <= '0;
`ifdef JTDD_ROMARB_TIMEOUT_EN
      cnt         <= 8'd0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: if (|miss) begin
          gnt          <= pick;
          bus.sdr_addr <= bus.req_addr[pick];
          bus.sdr_req  <= 1'b1;
          busy         <= 1'b1;
          st           <= REQ;
`ifdef JTDD_ROMARB_TIMEOUT_EN
          cnt <= 8'd0;
`endif
        end
        REQ: if (bus.sdr_ack) begin
          bus.sdr_req <= 1'b0;
          st          <= WAIT;
        end
        default: ;
      endcase
      if (fill) begin
        rr   <= (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
        st   <= IDLE;
        busy <= 1'b0;
      end
`ifdef JTDD_ROMARB_TIMEOUT_EN
      // abandon a stuck read; rr is left alone so the same requester retries
      if (st != IDLE && !fill) begin
        cnt <= cnt + 8'd1;
        if (cnt == TLIM) begin
          st          <= IDLE;
          bus.sdr_req <= 1'b0;
          busy        <= 1'b0;
          timeout_err <= 1'b1;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_jtdd_romarb.sv
// Directed scoreboard bench for jtdd_romarb: expected SDRAM addresses are queued at
// stimulus time and popped by a monitor on every sdr_req rise.
module tb_jtdd_romarb;
  localparam int AW = 18;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy, timeout_err;

  always #5 clk = ~clk;

  jtdd_romarb_if #(.AW(AW), .DW(DW)) bus ();

  jtdd_romarb #(.AW(AW), .DW(DW), .TOUT(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [AW-1:0] exp_q[$];
  int            ack_dly = 2;
  int            dst_dly = 5;
  bit            resp_en = 1'b1;
  logic          prev_req = 1'b0;
  logic [AW-1:0] ra;

  function automatic logic [7:0] mem(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ok(input int i, input string nm);
    for (int k = 0; k < 300 && !bus.req_ok[i]; k++) step();
    chk(nm, 32'(bus.req_ok[i]), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 300 && busy; k++) step();
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic wait_wait(input string nm);
    for (int k = 0; k < 300 && !(busy && !bus.sdr_req); k++) step();
    chk(nm, 32'(busy && !bus.sdr_req), 32'd1);
  endtask

  // SDRAM model: ack and data strobe at fixed offsets from the first sdr_req cycle
  initial begin
    bus.sdr_ack = 1'b0;
    bus.sdr_dst = 1'b0;
    bus.sdr_din = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en && bus.sdr_req) begin
        ra = bus.sdr_addr;
        for (int c = 0; c <= dst_dly; c++) begin
          bus.sdr_ack = (c == ack_dly);
          bus.sdr_dst = (c == dst_dly);
          bus.sdr_din = (c == dst_dly) ? mem(ra) : 8'h00;
          @(posedge clk);
          #1;
        end
        bus.sdr_ack = 1'b0;
        bus.sdr_dst = 1'b0;
      end
    end
  end

  initial begin
    int drops;
    bus.req_cs   = '0;
    bus.req_addr = '0;
    bus.flush    = 1'b0;

    fork
      begin
        logic [AW-1:0] e;
        forever begin
          @(negedge clk);
          if (bus.sdr_req && !prev_req) begin
            if (exp_q.size() == 0)
              chk("unexpected_req", 32'(bus.sdr_addr), 32'hFFFF_FFFF);
            else begin
              e = exp_q.pop_front();
              chk("sdr_addr", 32'(bus.sdr_addr), 32'(e));
            end
          end
          prev_req = bus.sdr_req;
        end
      end
    join_none

    // reset state
    repeat (3) step();
    chk("rst_sdr_req", 32'(bus.sdr_req), 32'd0);
    chk("rst_sdr_addr", 32'(bus.sdr_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ok", 32'(bus.req_ok), 32'd0);
    chk("rst_req_data", 32'(bus.req_data), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    rstn = 1'b1;
    repeat (2) step();

    // basic miss then hits: ack at +2, data at +5
    exp_q.push_back(18'h08000);
    bus.req_addr[0] = 18'h08000;
    bus.req_cs = 3'b001;
    step();
    chk("miss_req_lat", 32'(bus.sdr_req), 32'd1);
    chk("miss_busy", 32'(busy), 32'd1);
    repeat (5) step();
    chk("miss_ok_early", 32'(bus.req_ok[0]), 32'd0);
    step();
    chk("miss_ok_lat", 32'(bus.req_ok[0]), 32'd1);
    chk("miss_data", 32'(bus.req_data[0]), 32'h5A);
    chk("miss_done_busy", 32'(busy), 32'd0);
    drops = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!bus.req_ok[0] || bus.sdr_req) drops++;
    end
    chk("hit_hold", 32'(drops), 32'd0);
    bus.req_cs = 3'b000;
    #1;
    chk("cs_drop_ok", 32'(bus.req_ok[0]), 32'd0);

    // round robin from reset, main re-misses during the snd fill
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    ack_dly = 1;
    dst_dly = 3;
    exp_q.push_back(18'h08010);
    exp_q.push_back(18'h01010);
    exp_q.push_back(18'h20020);
    bus.req_addr = {18'h20020, 18'h01010, 18'h08010};
    bus.req_cs = 3'b111;
    wait_ok(0, "rr_main_ok");
    chk("rr_main_data", 32'(bus.req_data[0]), 32'h4A);
    for (int k = 0; k < 300 && !(bus.sdr_req && bus.sdr_addr == 18'h20020); k++) step();
    chk("rr_snd_gnt", 32'(bus.sdr_addr), 32'h20020);
    chk("rr_sub_ok", 32'(bus.req_ok[1]), 32'd1);
    chk("rr_sub_data", 32'(bus.req_data[1]), 32'h4A);
    exp_q.push_back(18'h08020);
    exp_q.push_back(18'h01020);
    bus.req_addr[0] = 18'h08020;
    bus.req_addr[1] = 18'h01020;
    wait_ok(2, "rr_snd_ok");
    chk("rr_snd_data", 32'(bus.req_data[2]), 32'h7A);
    wait_ok(0, "rr_main2_ok");
    chk("rr_main2_data", 32'(bus.req_data[0]), 32'h7A);
    wait_ok(1, "rr_sub2_ok");
    chk("rr_sub2_data", 32'(bus.req_data[1]), 32'h7A);
    wait_idle("rr_idle");

    // sub address changes while its read is outstanding
    repeat (3) step();
    ack_dly = 2;
    dst_dly = 5;
    exp_q.push_back(18'h01000);
    exp_q.push_back(18'h01001);
    bus.req_cs = 3'b010;
    bus.req_addr[1] = 18'h01000;
    wait_wait("aw_in_wait");
    bus.req_addr[1] = 18'h01001;
    wait_idle("aw_fill_done");
    chk("aw_ok_stale", 32'(bus.req_ok[1]), 32'd0);
    chk("aw_data_stale", 32'(bus.req_data[1]), 32'h5A);
    wait_ok(1, "aw_ok_new");
    chk("aw_data_new", 32'(bus.req_data[1]), 32'h5B);
    wait_idle("aw_idle");

    // ack and data strobe in the same cycle
    repeat (3) step();
    ack_dly = 2;
    dst_dly = 2;
    exp_q.push_back(18'h08030);
    bus.req_cs = 3'b001;
    bus.req_addr[0] = 18'h08030;
    repeat (3) step();
    chk("same_ok_early", 32'(bus.req_ok[0]), 32'd0);
    chk("same_busy", 32'(busy), 32'd1);
    step();
    chk("same_ok", 32'(bus.req_ok[0]), 32'd1);
    chk("same_no_wait", 32'(busy), 32'd0);
    chk("same_data", 32'(bus.req_data[0]), 32'h6A);

    // flush coinciding with the data strobe
    repeat (3) step();
    ack_dly = 2;
    dst_dly = 5;
    exp_q.push_back(18'h08040);
    exp_q.push_back(18'h08040);
    bus.req_addr[0] = 18'h08040;
    repeat (6) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_ok", 32'(bus.req_ok[0]), 32'd0);
    step();
    chk("flush_reissue", 32'(bus.sdr_req), 32'd1);
    wait_ok(0, "flush_ok_after");
    chk("flush_data", 32'(bus.req_data[0]), 32'h1A);

    // asynchronous reset while waiting for data
    repeat (3) step();
    exp_q.push_back(18'h01100);
    bus.req_cs = 3'b010;
    bus.req_addr[1] = 18'h01100;
    wait_wait("rst_mid_wait");
    rstn = 1'b0;
    #1;
    chk("rst_mid_req", 32'(bus.sdr_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ok", 32'(bus.req_ok), 32'd0);
    bus.req_cs = 3'b000;
    repeat (8) step();
    rstn = 1'b1;
    step();

    // SDRAM never acknowledges
    resp_en = 1'b0;
    exp_q.push_back(18'h08050);
    bus.req_addr[0] = 18'h08050;
    bus.req_cs = 3'b001;
    step();
    chk("tout_req", 32'(bus.sdr_req), 32'd1);
`ifdef JTDD_ROMARB_TIMEOUT_EN
    exp_q.push_back(18'h08050);
    repeat (15) step();
    chk("tout_req_held", 32'(bus.sdr_req), 32'd1);
    step();
    chk("tout_req_drop", 32'(bus.sdr_req), 32'd0);
    chk("tout_err", 32'(timeout_err), 32'd1);
    chk("tout_busy", 32'(busy), 32'd0);
    step();
    chk("tout_retry", 32'(bus.sdr_req), 32'd1);
    resp_en = 1'b1;
    wait_ok(0, "tout_ok");
    chk("tout_data", 32'(bus.req_data[0]), 32'h0A);
    chk("tout_sticky", 32'(timeout_err), 32'd1);
`else
    drops = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (!bus.sdr_req) drops++;
    end
    chk("hold_1000", 32'(drops), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_no_err", 32'(timeout_err), 32'd0);
    resp_en = 1'b1;
    wait_ok(0, "hold_ok");
    chk("hold_data", 32'(bus.req_data[0]), 32'h0A);
`endif

    bus.req_cs = 3'b000;
    repeat (5) step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
